// File: rtl/trace_reorder_ctrl_pkg.sv
// Shared trace event types and slot assignments for the reorder controller and its requesters.
package trace_reorder_ctrl_pkg;

    typedef enum logic [1:0] {
        TE_INVALID,
        TE_SWRITEBACK,
        TE_VWRITEBACK,
        TE_STORE
    } trace_event_type_t;

    // The top bit is left free for capture-side tagging; the controller never looks at it.
    typedef struct packed {
        logic              rsvd;
        trace_event_type_t ev_type;
        logic [60:0]       payload;
    } trace_event_t;

    localparam int TRACE_SLOT_MULTICYCLE = 0;
    localparam int TRACE_SLOT_MEM        = 3;
    localparam int TRACE_SLOT_SCYCLE     = 4;
    localparam int TRACE_SLOT_BRANCH     = 5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_reorder_ctrl_if.sv
// Ordered trace event stream: valid/ready handshake out of the reorder controller.
interface trace_reorder_ctrl_if #(
    parameter int EVENT_WIDTH = 64
);
    logic                   out_valid;
    logic [EVENT_WIDTH-1:0] out_data;
    logic                   out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/trace_reorder_ctrl_fifo.sv
// Synchronous FIFO with a registered head word so the consumer sees stable data under backpressure.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Next head comes from the write port when it lands exactly where the read pointer goes.
        if (cnt_d == '0)                         head_d = '0;
        else if (do_push && rd_ptr_d == wr_ptr_q) head_d = push_data;
        else                                     head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_data = head_q;
endmodule

// File: rtl/trace_reorder_ctrl.sv
// Trace reorder queue: requesters insert at a fixed distance from the head, the queue shifts
// one slot per cycle, and the head drains into an output FIFO in issue order.
module trace_reorder_ctrl
    import trace_reorder_ctrl_pkg::*;
#(
    parameter int QUEUE_LEN   = 7,
    parameter int NUM_PORTS   = 3,
    parameter int EVENT_WIDTH = 64,
    parameter int FIFO_DEPTH  = 8,
    localparam int SLOT_W     = $clog2(QUEUE_LEN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_PORTS-1:0]         ins_en,
    input  logic [NUM_PORTS*SLOT_W-1:0]  ins_slot,
    input  logic [NUM_PORTS*EVENT_WIDTH-1:0] ins_data,
    input  logic                         cancel_en,
    input  logic [SLOT_W-1:0]            cancel_slot,
    trace_reorder_ctrl_if.master         out_if,
    output logic [15:0]                  drop_count,
    output logic                         error
);
    localparam logic [SLOT_W:0] QLEN  = (SLOT_W+1)'(QUEUE_LEN);
    localparam int              CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [QUEUE_LEN-1:0]   vld_q, vld_d;
    logic [EVENT_WIDTH-1:0] slot_q [QUEUE_LEN];
    logic [EVENT_WIDTH-1:0] slot_d [QUEUE_LEN];
    logic [15:0]            drop_q, drop_d;
    logic                   err_q, err_d;
    logic                   emit, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_cnt;

    assign emit = enable && vld_q[0];
    assign pop  = out_if.out_ready && (fifo_cnt != '0);

    always_comb begin
        vld_d  = '0;
        slot_d = slot_q;
        err_d  = err_q;
        drop_d = drop_q;
        if (emit && fifo_full && !pop) drop_d = sat_inc16(drop_q);
        if (enable) begin
            for (int i = 0; i < QUEUE_LEN - 1; i++) begin
                vld_d[i]  = vld_q[i+1];
                slot_d[i] = slot_q[i+1];
            end
            // Ports are visited low to high, so an earlier winner already occupies the slot.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (ins_en[p]) begin
                    if ({1'b0, ins_slot[p*SLOT_W +: SLOT_W]} >= QLEN) begin
                        err_d = 1'b1;
                    end else if (vld_d[ins_slot[p*SLOT_W +: SLOT_W]]) begin
                        err_d = 1'b1;
                    end else begin
                        vld_d[ins_slot[p*SLOT_W +: SLOT_W]]  = 1'b1;
                        slot_d[ins_slot[p*SLOT_W +: SLOT_W]] = ins_data[p*EVENT_WIDTH +: EVENT_WIDTH];
                    end
                end
            end
            if (cancel_en && ({1'b0, cancel_slot} < QLEN)) vld_d[cancel_slot] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) slot_q <= slot_d;

    trace_fifo #(.WIDTH(EVENT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emit),
        .push_data (slot_q[0]),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt),
        .head_data (out_if.out_data)
    );

    assign out_if.out_valid = !fifo_empty;
    assign drop_count       = drop_q;
    assign error            = err_q;
endmodule

// File: doc/trace_reorder_ctrl.md
Name: trace_reorder_ctrl

Overview:
- Hardware trace reorder queue plus output buffer for cosimulation and on-chip debug capture.
- Pipeline stages retire events out of issue order. Each requester inserts its event at a fixed slot distance from the queue head, and the queue shifts one slot per cycle, so events leave in issue order.
- Ordered events go to a small FIFO with a valid/ready output that feeds debug_trace capture or a host dump path.

Parameters:
- QUEUE_LEN, 7, number of reorder slots (slot 0 = head).
- NUM_PORTS, 3, number of insertion requesters.
- EVENT_WIDTH, 64, bits per event; bit EVENT_WIDTH-1 is unused by the controller, and occupancy is tracked separately.
- FIFO_DEPTH, 8, output FIFO entries (power of 2).
- SLOT_W, $clog2(QUEUE_LEN), derived slot index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  trace enabled; when low, the queue is cleared and insertions are ignored.
- ins_en  in  NUM_PORTS  per-port insert request.
- ins_slot  in  NUM_PORTS*SLOT_W  per-port target slot.
- ins_data  in  NUM_PORTS*EVENT_WIDTH  per-port event payload.
- cancel_en  in  1  invalidate one slot (rollback / failed sync store).
- cancel_slot  in  SLOT_W  slot to invalidate.
- out_valid  out  1  FIFO non-empty.
- out_data  out  EVENT_WIDTH  FIFO head event.
- out_ready  in  1  consumer accepts out_data when out_valid and out_ready.
- drop_count  out  16  events lost to a full FIFO; saturates at 16'hFFFF.
- error  out  1  sticky: slot collision or out-of-range slot.

Behaviour:
- Reset (synchronous): all slot valid bits 0, FIFO empty, out_valid=0, out_data=0, drop_count=0, error=0. A reset mid-operation discards all queued and buffered events.
- State per slot: valid bit plus payload. FIFO: read pointer, write pointer, count (0..FIFO_DEPTH).
- Per-edge sequence when enable=1, applied in order to the same next-state:
  1. Emit: if slot[0] is valid, push it to the FIFO. If the FIFO is full and no pop happens this edge, drop the event and increment drop_count (saturating). A pop and a push on the same edge with the FIFO full succeeds.
  2. Shift: slot[i] <= slot[i+1] for i < QUEUE_LEN-1; slot[QUEUE_LEN-1] <= invalid.
  3. Insert: for each port with ins_en, write the post-shift slot[ins_slot].
     - Target already valid after the shift: keep the existing event, drop the new one, set error.
     - Two ports targeting the same slot: the lowest port index wins; set error.
     - ins_slot >= QUEUE_LEN: ignore the request; set error.
  4. Cancel: if cancel_en and cancel_slot < QUEUE_LEN, clear the post-insert valid of cancel_slot. This includes an event inserted on the same edge. cancel_slot out of range is ignored; it does not set error.
- enable=0:
  - All slot valid bits are cleared on that edge; insert and cancel are ignored.
  - No emit from the queue.
  - The FIFO still drains via out_ready.
- Latency: an event inserted at slot k on edge T is at the head after edge T+k, is pushed on edge T+k+1, and out_valid rises after that edge if the FIFO was empty. Total k+1 cycles.
- Ordering guarantee: A inserted at slot a on cycle t and B at slot b on cycle u leave in order of (t+a) versus (u+b). Requesters choose slots so that this equals issue order.
- FIFO: out_data is registered from the head entry and is stable while out_valid=1 and out_ready=0. out_valid=0 when count=0. Pointers wrap modulo FIFO_DEPTH.
- Once set, error stays high until reset.

Decomposition:
- defines.v gains:
  - trace_event_type_t: TE_INVALID, TE_SWRITEBACK, TE_VWRITEBACK, TE_STORE.
  - trace_event_t packed struct.
  - TRACE_SLOT_MULTICYCLE=0, TRACE_SLOT_MEM=3, TRACE_SLOT_SCYCLE=4, TRACE_SLOT_BRANCH=5, so that testbench and RTL share slot assignments.
- One sub-module, trace_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on WIDTH and DEPTH.
- The reorder slots and insertion logic stay in trace_reorder_ctrl.

Test Plan:
- Single event: port0 inserts 64'hA at slot 4, out_ready=1 → out_valid rises 5 cycles after the insert edge with out_data=64'hA; error=0.
- Reorder: cycle 0 port0 inserts X at slot 4; cycle 1 port1 inserts Y at slot 0 → Y exits before X, out_data sequence is Y then X.
- Collision: cycle 0 inserts E1 at slot 3, cycle 1 inserts E2 at slot 2 (same post-shift slot) → only E1 emerges, error=1 and stays 1; same-cycle ports 0 and 2 both to slot 1 → port0 data emerges.
- Cancel: insert at slot 4 with cancel_en=1 and cancel_slot=4 on the same edge → nothing emitted; cancel of slot 2 one cycle after inserting at slot 3 → nothing emitted.
- Backpressure: out_ready=0, 10 events at slot 0 on consecutive cycles → FIFO holds the first 8 and drop_count=2. Then out_ready=1 → the 8 events drain in order and out_valid falls.
- Reset and enable: queue 3 events, then assert reset for 1 cycle → out_valid=0 and drop_count=0 with no later emission. With enable=0 during inserts, nothing is queued, and pre-loaded FIFO entries still drain.
